noc_inport_handshake_adapter: RTL and testbench
===============================================

NOC_INPORT_HANDSHAKE_ADAPTER -- requirements
Module: noc_inport_handshake_adapter

Interface
REQ-001 SHALL have parameter DataWidth, default 64, the flit width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge triggered.
REQ-003 SHALL have port rst_n, input, 1 bit: the one clock domain's reset, asynchronous and active-low.
REQ-004 SHALL have port data_i, input, DataWidth bits: the flit from the upstream valid/ready source (e.g. Xilinx native FIFO read side).
REQ-005 SHALL have port data_valid_i, input, 1 bit: data_i is valid this cycle.
REQ-006 SHALL have port ready_o, output, 1 bit, registered: the adapter accepts data_i this cycle.
REQ-007 SHALL have port data_o, output, DataWidth bits, registered: the flit toward the NoC local inport.
REQ-008 SHALL have port data_valid_o, output, 1 bit, registered: each cycle it is high is exactly one flit transfer.
REQ-009 SHALL have port avail_i, input, 1 bit: the NoC local inport can receive flits.

Function
REQ-010 SHALL count a push in every cycle where data_valid_i=1 and ready_o=1.
REQ-011 SHALL register avail_i into avail_q, with no other use of avail_i.
REQ-012 SHALL store pushed flits in a 2-entry in-order buffer with occupancy count 0..2 and 1-bit head/tail pointers that wrap.
REQ-013 SHALL pop in every cycle where avail_q=1 and count!=0.
REQ-014 SHALL, on a pop, load data_o with the head entry at the next edge and set data_valid_o=1 there; otherwise data_valid_o=0 at the next edge and data_o holds.
REQ-015 SHALL implement a state machine on count with states EMPTY(0), ONE(1), TWO(2).
- Push only: count+1.
- Pop only: count-1.
- Push and pop together: count unchanged.
- No push in TWO; no pop in EMPTY.
REQ-016 SHALL set ready_o at each edge to (count_next!=2).
REQ-017 SHALL give a minimum latency of 2 cycles from push to data_valid_o, when the buffer is EMPTY and avail_q=1.
REQ-018 SHALL sustain one flit per cycle while avail_i stays 1.
REQ-019 SHALL, when avail_i falls in cycle t, emit at most two further flits, in cycles t and t+1, and none from t+2 until avail_q returns to 1.
REQ-020 SHALL resume popping in the cycle after avail_i returns high, so the first flit appears 2 cycles after that rise.
REQ-021 SHALL never drop, duplicate or reorder a flit, including under simultaneous push/pop at count=1 and at head/tail wrap-around.
REQ-022 SHALL ignore data_valid_i while ready_o=0.

Reset
REQ-023 SHALL, while rst_n=0, force count=0, pointers=0, avail_q=0, ready_o=0, data_valid_o=0 and data_o=0 immediately, without waiting for clk.
REQ-024 SHALL leave buffer storage unreset.
REQ-025 SHALL raise ready_o at the first clk edge after rst_n deasserts.
REQ-026 SHALL, on reset mid-operation, discard every buffered flit and emit no partial transfer.

Structure
REQ-027 SHALL take the EMPTY/ONE/TWO state encodings from the shared package noc_pkg.
REQ-028 SHALL place the 2-entry buffer, with pointers, count and full/empty flags, in sub-module noc_fifo2, parameterised by DataWidth.
REQ-029 SHALL keep the pop decision and output register in the top level.

Verification
REQ-030 SHALL test a single flit: reset release, avail_i=1, push 0xA5 -> data_valid_o=1 with data_o=0xA5 exactly 2 cycles after the push, then data_valid_o=0.
REQ-031 SHALL test streaming: avail_i=1, push 0x01..0x10 back-to-back -> 16 consecutive valid cycles in order, and ready_o never 0.
REQ-032 SHALL test backpressure: stream running, avail_i=0 at cycle t -> valids in t and t+1 only, buffer reaches TWO, ready_o=0, no flit lost; avail_i=1 -> remaining flits in order.
REQ-033 SHALL test the full boundary: avail_i=0 from reset, push 0x11,0x22 -> ready_o=0 from the 3rd cycle; held data_valid_i with 0x33 is not accepted until the first pop.
REQ-034 SHALL test async reset: rst_n=0 mid-stream between edges -> data_valid_o and ready_o go 0 before the next edge; after release, no stale flit appears.
REQ-035 SHALL test random stimulus: random data_valid_i and avail_i over 10000 cycles -> scoreboard finds in-order, lossless delivery, and never more than 2 valids after any avail_i fall.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: occupancy states of the two-entry inport buffer.
package noc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/noc_fifo2.sv
// Two-entry in-order flit buffer; the occupancy FSM doubles as the count.
import noc_pkg::*;

module noc_fifo2 #(
  parameter int DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [1:0]           state_next_o
);

  fifo_state_e          state_q, state_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DataWidth-1:0] mem_q [2];
  logic                 push_ok, pop_ok;

  // Guards make a push into TWO or a pop from EMPTY a no-op.
  assign push_ok = push_i & (state_q != TWO);
  assign pop_ok  = pop_i  & (state_q != EMPTY);

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    case (state_q)
      EMPTY:   if (push_ok) state_d = ONE;
      ONE: begin
        if (push_ok && !pop_ok)      state_d = TWO;
        else if (pop_ok && !push_ok) state_d = EMPTY;
      end
      TWO:     if (pop_ok) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign full_o       = (state_q == TWO);
  assign empty_o      = (state_q == EMPTY);
  assign state_next_o = state_d;

endmodule

// File: rtl/noc_inport_handshake_adapter.sv
// Bridges a valid/ready flit source onto a NoC local inport that signals
// availability rather than per-flit acceptance.
import noc_pkg::*;

module noc_inport_handshake_adapter #(
  parameter int DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 data_valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 data_valid_o,
  input  logic                 avail_i
);

  // Upstream handshake: a flit transfers on every cycle where data_valid_i
  // and ready_o are both high; data_valid_i is ignored while ready_o is low.
  // Downstream has no ready: each cycle data_valid_o is high is one transfer.

  logic                 avail_q;
  logic                 ready_q;
  logic                 valid_q, valid_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [DataWidth-1:0] head;
  logic                 push, pop;
  logic                 fifo_full, fifo_empty;
  logic [1:0]           state_next;

  assign push = data_valid_i & ready_q & ~fifo_full;
  assign pop  = avail_q & ~fifo_empty;

  noc_fifo2 #(
    .DataWidth (DataWidth)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (push),
    .data_i       (data_i),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .state_next_o (state_next)
  );

  always_comb begin
    valid_d = pop;
    data_d  = data_q;
    if (pop) data_d = head;
  end

  // avail_i is only ever seen through avail_q, bounding the post-fall tail to two flits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_q <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      avail_q <= avail_i;
      ready_q <= (state_next != TWO);
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ready_o      = ready_q;
  assign data_o       = data_q;
  assign data_valid_o = valid_q;

endmodule

// File: tb/tb_noc_inport_handshake_adapter.sv
// Bench for noc_inport_handshake_adapter: directed scenarios with hand-derived
// cycle expectations plus a scoreboard monitor over a randomised run.
module tb_noc_inport_handshake_adapter;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] data_i;
  logic         data_valid_i;
  logic         ready_o;
  logic [W-1:0] data_o;
  logic         data_valid_o;
  logic         avail_i;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];

  noc_inport_handshake_adapter #(.DataWidth(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .ready_o      (ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .avail_i      (avail_i)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    avail_i      = 1'b0;
    data_valid_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // scoreboard / monitor with an occupancy model of the adapter
  int   m_cnt   = 0;
  logic m_ready = 1'b0;
  logic m_valid = 1'b0;
  logic m_avq   = 1'b0;
  logic prev_av = 1'b0;
  int   since   = 0;

  always @(negedge clk) begin
    logic         m_push, m_pop;
    logic [W-1:0] e;
    if (!avail_i) since = prev_av ? 0 : (since < 1000 ? since + 1 : since);
    prev_av = avail_i;
    if (!rst_n) begin
      chk("rst_valid", {63'd0, data_valid_o}, 64'd0);
      chk("rst_ready", {63'd0, ready_o}, 64'd0);
      chk("rst_data", data_o, 64'd0);
      m_cnt = 0; m_ready = 1'b0; m_valid = 1'b0; m_avq = 1'b0;
      exp_q.delete();
    end else begin
      chk("mon_ready", {63'd0, ready_o}, {63'd0, m_ready});
      chk("mon_valid", {63'd0, data_valid_o}, {63'd0, m_valid});
      if (data_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_flit", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("flit_data", data_o, e);
        end
        if (!avail_i) chk("avail_fall_window", {63'd0, since >= 2}, 64'd0);
      end
      m_push = data_valid_i && m_ready;
      m_pop  = m_avq && (m_cnt != 0);
      if (m_push) exp_q.push_back(data_i);
      m_cnt   = m_cnt + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      m_valid = m_pop;
      m_ready = (m_cnt != 2);
      m_avq   = avail_i;
    end
  end

  initial begin
    logic [W-1:0] nxt;
    rst_n        = 1'b0;
    avail_i      = 1'b0;
    data_valid_i = 1'b0;
    data_i       = '0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_edge", {63'd0, ready_o}, 64'd0);
    step();
    @(negedge clk);
    chk("ready_after_release", {63'd0, ready_o}, 64'd1);

    // single flit: valid exactly two cycles after the push
    avail_i = 1'b1;
    repeat (3) step();
    data_valid_i = 1'b1; data_i = 64'hA5;
    @(negedge clk);
    chk("single_ready", {63'd0, ready_o}, 64'd1);
    step(); data_valid_i = 1'b0;
    @(negedge clk);
    chk("single_lat1", {63'd0, data_valid_o}, 64'd0);
    step();
    @(negedge clk);
    chk("single_lat2_valid", {63'd0, data_valid_o}, 64'd1);
    chk("single_lat2_data", data_o, 64'hA5);
    step();
    @(negedge clk);
    chk("single_after", {63'd0, data_valid_o}, 64'd0);

    // streaming 0x01..0x10
    for (int k = 0; k < 18; k++) begin
      step();
      data_valid_i = (k < 16);
      data_i       = W'(k + 1);
      @(negedge clk);
      chk("stream_ready", {63'd0, ready_o}, 64'd1);
      if (k >= 2) begin
        chk("stream_valid", {63'd0, data_valid_o}, 64'd1);
        chk("stream_data", data_o, W'(k - 1));
      end
    end
    step(); data_valid_i = 1'b0;
    @(negedge clk);
    chk("stream_end", {63'd0, data_valid_o}, 64'd0);

    // backpressure: avail_i low in cycles 8..11
    nxt = 64'h40;
    for (int j = 0; j < 16; j++) begin
      step();
      avail_i      = !(j >= 8 && j <= 11);
      data_valid_i = 1'b1;
      data_i       = nxt;
      @(negedge clk);
      if (j == 8 || j == 9 || j == 14) chk("bp_valid_hi", {63'd0, data_valid_o}, 64'd1);
      if (j >= 10 && j <= 13) begin
        chk("bp_valid_lo", {63'd0, data_valid_o}, 64'd0);
        chk("bp_ready_lo", {63'd0, ready_o}, 64'd0);
      end
      if (j == 14) chk("bp_ready_back", {63'd0, ready_o}, 64'd1);
      if (ready_o) nxt = nxt + 1;
    end
    step(); data_valid_i = 1'b0; avail_i = 1'b1;
    repeat (6) step();
    @(negedge clk);
    chk("bp_drained", W'(exp_q.size()), 64'd0);

    // asynchronous reset between edges mid-stream
    for (int k = 0; k < 5; k++) begin
      step();
      data_valid_i = 1'b1;
      data_i       = W'(8'h70 + k);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", {63'd0, data_valid_o}, 64'd0);
    chk("async_ready", {63'd0, ready_o}, 64'd0);
    chk("async_data", data_o, 64'd0);
    data_valid_i = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no_stale", {63'd0, data_valid_o}, 64'd0);
      step();
    end

    // full boundary with avail_i low from reset
    do_reset();
    @(negedge clk);
    chk("full_c0_ready", {63'd0, ready_o}, 64'd0);
    for (int c = 1; c <= 10; c++) begin
      step();
      data_valid_i = (c <= 7);
      data_i       = (c == 1) ? 64'h11 : (c == 2) ? 64'h22 : 64'h33;
      avail_i      = (c >= 5);
      @(negedge clk);
      if (c <= 2 || c == 7) chk("full_ready_hi", {63'd0, ready_o}, 64'd1);
      if (c >= 3 && c <= 6) chk("full_ready_lo", {63'd0, ready_o}, 64'd0);
      if (c < 7 || c == 10) chk("full_valid_lo", {63'd0, data_valid_o}, 64'd0);
      if (c == 7) chk("full_out11", data_o, 64'h11);
      if (c == 8) chk("full_out22", data_o, 64'h22);
      if (c == 9) chk("full_out33", data_o, 64'h33);
    end

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      step();
      data_valid_i = ($urandom_range(0, 1) == 1);
      data_i       = {$urandom, $urandom};
      avail_i      = ($urandom_range(0, 9) < 7);
    end
    step(); data_valid_i = 1'b0; avail_i = 1'b1;
    repeat (8) step();
    @(negedge clk);
    chk("random_drained", W'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
